// File: rtl/icache_front_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states and the
// bookkeeping entry kept for every request the core has accepted.
package mem_if_def;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOK    = 2'd1,
    S_CACHEOP = 2'd2
  } front_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        cache;
    logic        drop;
  } fetch_entry_t;

endpackage

// File: rtl/icache_front_if.sv
// CPU-side request/response and core-side m0/m1 signals of the fetch front end.
// slave is the front end's view; master is the view of the CPU plus core.
interface icache_front_if #(
  parameter int FETCH_WIDTH = 2
);
  logic                      req_valid;
  logic [31:0]               req_addr;
  logic                      req_uncache;
  logic                      req_cache_valid;
  logic                      req_cache_op;
  logic                      req_addr_ok;

  logic                      resp_data_ok;
  logic [32*FETCH_WIDTH-1:0] resp_rdata;
  logic [FETCH_WIDTH-1:0]    resp_mask;
  logic [31:0]               resp_addr;
  logic                      flush;

  logic                      m0_valid;
  logic [31:0]               m0_addr;
  logic                      m0_uncache;
  logic                      m0_cache_valid;
  logic                      m0_cache_op;
  logic                      m0_addr_ok;
  logic                      m1_data_ok;
  logic [32*FETCH_WIDTH-1:0] m1_rdata;

  modport slave (
    input  req_valid, req_addr, req_uncache, req_cache_valid, req_cache_op, flush,
    input  m0_addr_ok, m1_data_ok, m1_rdata,
    output req_addr_ok, resp_data_ok, resp_rdata, resp_mask, resp_addr,
    output m0_valid, m0_addr, m0_uncache, m0_cache_valid, m0_cache_op
  );

  modport master (
    output req_valid, req_addr, req_uncache, req_cache_valid, req_cache_op, flush,
    output m0_addr_ok, m1_data_ok, m1_rdata,
    input  req_addr_ok, resp_data_ok, resp_rdata, resp_mask, resp_addr,
    input  m0_valid, m0_addr, m0_uncache, m0_cache_valid, m0_cache_op
  );
endinterface

// File: rtl/icache_front_fifo.sv
// In-order queue of outstanding fetches; flush_mark tags every held entry as
// dropped so it still pops but is never forwarded.
module icache_front_fifo
  import mem_if_def::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  input  logic                   flush_mark,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count_nxt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    mem_d    = mem_q;
    if (flush_mark) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i].drop = 1'b1;
    end
    // Written after the flush mark so a fresh entry always starts undropped.
    if (do_push) mem_d[wr_ptr_q] = push_entry;
    head      = mem_q[rd_ptr_q];
    count_nxt = count_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/icache_front.sv
// Instruction-fetch front end: forwards CPU fetches to the core, tracks them in
// order and returns masked fetch groups.
//   state     | meaning
//   S_IDLE    | nothing outstanding
//   S_LOOK    | normal fetches outstanding
//   S_CACHEOP | a CACHE instruction is outstanding; no new accepts
module icache_front
  import mem_if_def::*;
#(
  parameter int DEPTH       = 2,
  parameter int FETCH_WIDTH = 2
) (
  input  logic          clk,
  input  logic          resetn,
  icache_front_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  front_state_e           state_q, state_d;
  fetch_entry_t           push_entry, head;
  logic                   full, empty;
  logic                   can_accept, accept, pop_ok;
  logic [CW-1:0]          count_nxt;
  logic [LW-1:0]          lane;
  logic [FETCH_WIDTH-1:0] resp_mask_c;

  always_comb begin
    can_accept = resetn & ~bus.flush & ~full & (state_q != S_CACHEOP)
               & (~bus.req_cache_valid | empty);
    accept     = bus.req_valid & can_accept & bus.m0_addr_ok;
    pop_ok     = resetn & bus.m1_data_ok & ~empty;
    push_entry = '{addr: bus.req_addr, cache: bus.req_cache_valid, drop: 1'b0};
  end

  icache_front_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop_ok),
    .flush_mark (bus.flush),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count_nxt  (count_nxt)
  );

  // Lanes before the entry's word inside its aligned group are not valid.
  always_comb begin
    lane        = LW'((head.addr >> 2) & 32'(FETCH_WIDTH - 1));
    resp_mask_c = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      resp_mask_c[i] = resetn & (LW'(i) >= lane);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = bus.req_cache_valid ? S_CACHEOP : S_LOOK;
      S_LOOK:    if (count_nxt == '0) state_d = S_IDLE;
      S_CACHEOP: if (pop_ok) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign bus.m0_valid       = bus.req_valid & can_accept;
  assign bus.m0_addr        = bus.req_addr;
  assign bus.m0_uncache     = bus.req_uncache;
  assign bus.m0_cache_valid = bus.req_cache_valid;
  assign bus.m0_cache_op    = bus.req_cache_op;
  assign bus.req_addr_ok    = accept;

  assign bus.resp_data_ok = pop_ok & ~head.drop & ~bus.flush & ~head.cache;
  assign bus.resp_rdata   = bus.m1_rdata;
  assign bus.resp_addr    = head.addr;
  assign bus.resp_mask    = resp_mask_c;

endmodule
